// File: rtl/grey_conv_axis_pipe.sv
`default_nettype none
// grey_conv_axis_pipe: 2-stage AXI4-Stream RGB-to-grey pipeline with per-frame output mode and frame counter.
// Build option GREY_ROUND_EN: round the luma sum half-up before the shift instead of truncating.
module grey_conv_axis_pipe #(
  parameter int DATA_W    = 8,
  parameter int COEF_FRAC = 8,
  parameter int COEF_R    = 77,
  parameter int COEF_G    = 150,
  parameter int COEF_B    = 29,
  parameter int FCNT_W    = 16
) (
  input  logic                axi_clk,
  input  logic                axi_resetn,
  input  logic [3*DATA_W-1:0] s_axis_tdata,
  input  logic [2:0]          s_axis_tkeep,
  input  logic                s_axis_tlast,
  input  logic                s_axis_tuser,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic [3*DATA_W-1:0] m_axis_tdata,
  output logic [2:0]          m_axis_tkeep,
  output logic                m_axis_tlast,
  output logic                m_axis_tuser,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  input  logic [1:0]          mode,
  output logic [FCNT_W-1:0]   frame_cnt
);

  localparam int PW = DATA_W + COEF_FRAC + 1;
  localparam int SW = DATA_W + COEF_FRAC + 3;
  localparam int TW = 3 * DATA_W;
  localparam logic [SW-1:0] MAXV = SW'((1 << DATA_W) - 1);
`ifdef GREY_ROUND_EN
  localparam logic [SW-1:0] RND = SW'(1) << (COEF_FRAC - 1);
`else
  localparam logic [SW-1:0] RND = '0;
`endif

  logic              adv1, adv2, s_acc;
  logic              v1_q, v2_q, rdy_en_q;
  logic [1:0]        frame_mode_q, mode_eff_d, mode1_q;
  logic [PW-1:0]     prod_r_d, prod_g_d, prod_b_d;
  logic [PW-1:0]     prod_r_q, prod_g_q, prod_b_q;
  logic [TW-1:0]     pix1_q;
  logic [2:0]        keep1_q;
  logic              last1_q, user1_q;
  logic [SW-1:0]     sum_d, shr_d;
  logic [DATA_W-1:0] grey_d, inv_d;
  logic [TW-1:0]     tdata_d, tdata_q;
  logic [2:0]        keep_q;
  logic              last_q, user_q;
  logic [FCNT_W-1:0] fcnt_q;

  assign adv2          = ~v2_q | m_axis_tready;
  assign adv1          = ~v1_q | adv2;
  // Held low for the first cycle after reset release so no beat is taken while coming out of reset.
  assign s_axis_tready = adv1 & rdy_en_q;
  assign s_acc         = s_axis_tvalid & s_axis_tready;
  // The SOF beat already uses the newly requested mode; other beats follow the frame's mode.
  assign mode_eff_d    = s_axis_tuser ? mode : frame_mode_q;

  assign prod_r_d = PW'(s_axis_tdata[DATA_W-1:0])        * PW'(COEF_R);
  assign prod_g_d = PW'(s_axis_tdata[2*DATA_W-1:DATA_W]) * PW'(COEF_G);
  assign prod_b_d = PW'(s_axis_tdata[TW-1:2*DATA_W])     * PW'(COEF_B);

  always_comb begin
    sum_d   = SW'(prod_r_q) + SW'(prod_g_q) + SW'(prod_b_q) + RND;
    shr_d   = sum_d >> COEF_FRAC;
    grey_d  = (shr_d > MAXV) ? '1 : shr_d[DATA_W-1:0];
    inv_d   = ~grey_d;
    tdata_d = pix1_q;
    case (mode1_q)
      2'b00:   tdata_d = pix1_q;
      2'b01:   tdata_d = {grey_d, grey_d, grey_d};
      2'b10:   tdata_d = {{(2*DATA_W){1'b0}}, grey_d};
      default: tdata_d = {inv_d, inv_d, inv_d};
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      rdy_en_q     <= 1'b0;
      frame_mode_q <= 2'b00;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      prod_r_q     <= '0;
      prod_g_q     <= '0;
      prod_b_q     <= '0;
      pix1_q       <= '0;
      keep1_q      <= '0;
      last1_q      <= 1'b0;
      user1_q      <= 1'b0;
      mode1_q      <= 2'b00;
      tdata_q      <= '0;
      keep_q       <= '0;
      last_q       <= 1'b0;
      user_q       <= 1'b0;
      fcnt_q       <= '0;
    end else begin
      rdy_en_q <= 1'b1;
      if (s_acc && s_axis_tuser) frame_mode_q <= mode;
      if (adv1) begin
        v1_q     <= s_acc;
        prod_r_q <= prod_r_d;
        prod_g_q <= prod_g_d;
        prod_b_q <= prod_b_d;
        pix1_q   <= s_axis_tdata;
        keep1_q  <= s_axis_tkeep;
        last1_q  <= s_axis_tlast;
        user1_q  <= s_axis_tuser;
        mode1_q  <= mode_eff_d;
      end
      if (adv2) begin
        v2_q    <= v1_q;
        tdata_q <= tdata_d;
        keep_q  <= keep1_q;
        last_q  <= last1_q;
        user_q  <= user1_q;
      end
      if (v2_q && m_axis_tready && user_q) fcnt_q <= fcnt_q + FCNT_W'(1);
    end
  end

  assign m_axis_tvalid = v2_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = keep_q;
  assign m_axis_tlast  = last_q;
  assign m_axis_tuser  = user_q;
  assign frame_cnt     = fcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_grey_conv_axis_pipe.sv
`default_nettype none
// tb_grey_conv_axis_pipe: randomized scoreboard bench for grey_conv_axis_pipe (default parameters).
module tb_grey_conv_axis_pipe;

  localparam int CR = 77, CG = 150, CB = 29;
`ifdef GREY_ROUND_EN
  localparam int RADD = 128;
  localparam int R_EXP = 77, G_EXP = 149, B_EXP = 29;
`else
  localparam int RADD = 0;
  localparam int R_EXP = 76, G_EXP = 149, B_EXP = 28;
`endif

  logic        clk, rstn;
  logic [23:0] s_tdata, m_tdata;
  logic [2:0]  s_tkeep, m_tkeep;
  logic        s_tlast, s_tuser, s_tvalid, s_tready;
  logic        m_tlast, m_tuser, m_tvalid, m_tready;
  logic [1:0]  mode;
  logic [15:0] fcnt;

  int checks = 0;
  int errors = 0;
  int ready_pct = 100;

  logic [28:0] exp_q[$];
  logic [28:0] last_out, prev_out, exp_item;
  logic [1:0]  fmode_m, em;
  logic [15:0] fcnt_m;
  bit          stall_prev;

  grey_conv_axis_pipe dut (
    .axi_clk(clk), .axi_resetn(rstn),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .m_axis_tuser(m_tuser), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .mode(mode), .frame_cnt(fcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Luma from the weighted channel sum, then output formatting per mode.
  function automatic logic [23:0] ref_pix(input logic [23:0] px, input logic [1:0] md);
    int y;
    logic [7:0] y8;
    y = (int'(px[7:0]) * CR + int'(px[15:8]) * CG + int'(px[23:16]) * CB + RADD) / 256;
    if (y > 255) y = 255;
    y8 = y[7:0];
    case (md)
      2'b00:   return px;
      2'b01:   return {y8, y8, y8};
      2'b10:   return {16'h0000, y8};
      default: return {3{8'(255 - y)}};
    endcase
  endfunction

  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1 m_tready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  always @(negedge clk) begin
    if (!rstn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        chk("hold_stalled", {m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser}, {1'b1, prev_out});
      if (s_tvalid && s_tready) begin
        em = s_tuser ? mode : fmode_m;
        if (s_tuser) fmode_m = mode;
        exp_q.push_back({ref_pix(s_tdata, em), s_tkeep, s_tlast, s_tuser});
      end
      if (m_tvalid && m_tready) begin
        last_out = {m_tdata, m_tkeep, m_tlast, m_tuser};
        if (exp_q.size() == 0) begin
          chk("spurious_beat", 64'(last_out), 64'h1_0000_0000);
        end else begin
          exp_item = exp_q.pop_front();
          chk("out_beat", 64'(last_out), 64'(exp_item));
        end
        chk("frame_cnt", 64'(fcnt), 64'(fcnt_m));
        if (m_tuser) fcnt_m = fcnt_m + 16'd1;
      end
      stall_prev = m_tvalid && !m_tready;
      prev_out   = {m_tdata, m_tkeep, m_tlast, m_tuser};
    end
  end

  task automatic clear_model();
    exp_q.delete();
    fmode_m = 2'b00;
    fcnt_m  = 16'd0;
  endtask

  task automatic drive_beat(input logic [23:0] d, input logic [2:0] k, input logic l,
                            input logic u, input logic [1:0] md);
    int  n = 0;
    logic acc;
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u; mode = md; s_tvalid = 1'b1;
    forever begin
      @(negedge clk) acc = s_tready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 2000) begin
        chk("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1 n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #(10 * 80000);
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
    s_tuser = 1'b0; mode = 2'b00; stall_prev = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser}, 64'd0);
    chk("rst_fcnt", 64'(fcnt), 64'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1 chk("rdy_after_rst", 64'(s_tready), 64'd1);

    // Two-cycle latency on an empty pipe, grey of equal channels, SOF counted.
    ready_pct = 100;
    repeat (2) @(posedge clk);
    #1;
    s_tdata = 24'hC8C8C8; s_tkeep = 3'b111; s_tlast = 1'b0; s_tuser = 1'b1; mode = 2'b01;
    s_tvalid = 1'b1;
    @(posedge clk);
    #1 s_tvalid = 1'b0;
    chk("latency_c1", 64'(m_tvalid), 64'd0);
    @(posedge clk);
    #1 chk("latency_c2", 64'(m_tvalid), 64'd1);
    @(posedge clk);
    #1 chk("grey_200", 64'(last_out[28:5]), 64'hC8C8C8);
    chk("fcnt_after_sof", 64'(fcnt), 64'd1);
    for (int i = 0; i < 5; i++) drive_beat(24'hC8C8C8, 3'b111, i == 4, 1'b0, 2'b01);
    drain();
    chk("grey_200_stream", 64'(last_out[28:5]), 64'hC8C8C8);

    // Per-channel coefficients.
    drive_beat(24'h0000FF, 3'b111, 1'b0, 1'b0, 2'b01);
    drain();
    chk("coef_red", 64'(last_out[12:5]), 64'(R_EXP));
    drive_beat(24'h00FF00, 3'b111, 1'b0, 1'b0, 2'b01);
    drain();
    chk("coef_green", 64'(last_out[12:5]), 64'(G_EXP));
    drive_beat(24'hFF0000, 3'b111, 1'b1, 1'b0, 2'b01);
    drain();
    chk("coef_blue", 64'(last_out[12:5]), 64'(B_EXP));

    // Mode changes only take effect on the next SOF beat.
    drive_beat(24'hC8C8C8, 3'b111, 1'b0, 1'b1, 2'b01);
    drive_beat(24'hC8C8C8, 3'b111, 1'b0, 1'b0, 2'b11);
    drain();
    chk("latch_mid_frame", 64'(last_out[28:5]), 64'hC8C8C8);
    drive_beat(24'hC8C8C8, 3'b111, 1'b0, 1'b1, 2'b11);
    drain();
    chk("latch_sof_inv", 64'(last_out[28:5]), 64'h373737);
    drive_beat(24'hC8C8C8, 3'b111, 1'b0, 1'b0, 2'b01);
    drain();
    chk("latch_keep_inv", 64'(last_out[28:5]), 64'h373737);
    drive_beat(24'hC8C8C8, 3'b111, 1'b0, 1'b1, 2'b10);
    drain();
    chk("mode_red_lane", 64'(last_out[28:5]), 64'h0000C8);

    // Random backpressure in bypass; non-SOF beats carry random mode that must be ignored.
    ready_pct = 50;
    for (int i = 0; i < 1000; i++) begin
      drive_beat(24'($urandom), 3'($urandom), (i % 10) == 9, (i % 50) == 0,
                 ((i % 50) == 0) ? 2'b00 : 2'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();

    // Random modes per frame.
    ready_pct = 70;
    for (int i = 0; i < 300; i++)
      drive_beat(24'($urandom), 3'($urandom), (i % 10) == 9, (i % 20) == 0, 2'($urandom));
    drain();

    // Asynchronous reset with the pipe full.
    ready_pct = 0;
    repeat (2) @(posedge clk);
    #1;
    drive_beat(24'hAAAAAA, 3'b111, 1'b0, 1'b1, 2'b01);
    drive_beat(24'hBBBBBB, 3'b111, 1'b0, 1'b0, 2'b01);
    @(posedge clk);
    #2 rstn = 1'b0;
    clear_model();
    #1;
    chk("async_rst_valid", 64'(m_tvalid), 64'd0);
    chk("async_rst_fcnt", 64'(fcnt), 64'd0);
    chk("async_rst_data", 64'(m_tdata), 64'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    ready_pct = 100;
    @(posedge clk);
    #1 chk("rdy_after_async_rst", 64'(s_tready), 64'd1);
    drive_beat(24'h123456, 3'b101, 1'b1, 1'b1, 2'b00);
    drain();
    chk("first_post_rst", 64'(last_out), 64'({24'h123456, 3'b101, 1'b1, 1'b1}));
    chk("fcnt_post_rst", 64'(fcnt), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
